hazard_control: RTL
===================

# hazard_control

Pipeline hazard controller for the five-stage ARMv8 core. Keeps a registered shadow copy of the destination and control state of the ID/EX, EX/MEM and MEM/WB stages. From that state it produces the registered `forwardA`/`forwardB` selects consumed by the execution stage. It also produces load-use stall, taken-branch flush and data-memory freeze controls for the PC, IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- `FLUSH_DEPTH`, default 3: number of younger instructions squashed on a taken branch. Legal values are 1–3: IF/ID, ID/EX, EX/MEM.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; one clock domain.
- `id_rn`, `id_rm` in 5 each: source registers of the instruction in ID.
- `id_uses_rm` in 1: the instruction in ID reads `id_rm`; when low, `forwardB` selects the register/immediate path.
- `id_rd` in 5: destination register of the instruction in ID.
- `id_reg_write` in 1: the instruction in ID writes `id_rd`.
- `id_mem_read` in 1: the instruction in ID is a load.
- `branch_taken` in 1: the branch in MEM is resolved taken.
- `dmem_wait` in 1: data memory not ready; the whole pipeline freezes.
- `forwardA`, `forwardB` out 2 each: registered ALU operand selects for the instruction in EX.
  - 00: register file value.
  - 10: EX/MEM ALU result.
  - 01: WB write-back value.
- `pc_write` out 1: the PC may update.
- `if_id_write` out 1: the IF/ID register may load.
- `id_ex_bubble` out 1: load zeros/NOP control into ID/EX.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1 each: squash the stage.
- `stall_cycles`, `flush_count` out 32 each: performance counters. These are active only with `HAZARD_PERF_EN`.

## Operation
- Shadow stages hold the fields `valid`, `rd`, `reg_write`, `mem_read`.
  - On a normal advance: ID/EX ← ID inputs, EX/MEM ← ID/EX, MEM/WB ← EX/MEM.
- X31 (XZR) is never a hazard source. Any comparison with `rd == 31` is false.
- Forward select is computed at ID and registered into `forwardA`/`forwardB` on the advance edge:
  - Select 10 if the current ID/EX shadow is valid, has `reg_write` set, and its `rd` equals the source register.
  - Otherwise select 01 if the current EX/MEM shadow matches under the same conditions.
  - Otherwise select 00.
  - EX/MEM has priority over WB.
  - `forwardB` is 00 whenever `id_uses_rm` = 0.
- Load-use stall: the ID/EX shadow is a valid load, and its `rd` matches `id_rn`, or matches `id_rm` with `id_uses_rm` set. In that case, combinationally:
  - `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1.
  - At the next edge the ID/EX shadow becomes invalid and the older stages advance.
  - Forward selects recompute on the following cycle; the load is then in EX/MEM, giving 01 at EX.
  - Exactly one stall cycle per load-use hazard.
- Taken branch: assert `flush_if_id`, `flush_id_ex` and (if `FLUSH_DEPTH` = 3) `flush_ex_mem` for one cycle. The corresponding shadow stages are invalidated at the edge. `pc_write` stays 1 so the target is loaded.
- Freeze: with `dmem_wait` = 1, all shadow state and forward registers hold. `pc_write` = `if_id_write` = 0, and no bubble or flush is asserted.
- Priority: `reset` > `dmem_wait` > `branch_taken` > load-use. A branch coinciding with a load-use hazard flushes and does not stall.

## Timing
- Reset values:
  - All shadow `valid`/`reg_write`/`mem_read` = 0 and `rd` = 31.
  - `forwardA` = `forwardB` = 00.
  - Counters = 0.
  - Combinational outputs with idle inputs: `pc_write` = `if_id_write` = 1, bubble and flushes = 0.
- Reset asserted mid-operation clears all state immediately, independent of `clk`. After deassertion, the first edge loads ID/EX normally.
- Control outputs (`pc_write`, `if_id_write`, `id_ex_bubble`, flushes) are combinational from the ID inputs and registered shadow state. Zero-cycle latency.
- Forward selects have one-cycle latency: values presented at ID in cycle N appear on `forwardA`/`forwardB` in cycle N+1, when that instruction is in EX.
- A `dmem_wait` lasting k cycles delays the pipeline exactly k cycles. No state is lost, and a pending load-use stall resumes afterwards.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cycles` increments on each cycle with a load-use stall or freeze.
  - `flush_count` increments on each taken-branch flush.
  - Both saturate at 0xFFFF_FFFF and are cleared by reset.
- `HAZARD_PERF_EN` not defined: counter logic is absent and both ports are tied to 0.

## Structure
- Shared package `pipeline_pkg`:
  - Constants `FWD_REG` = 2'b00, `FWD_EXMEM` = 2'b10, `FWD_MEMWB` = 2'b01, `XZR` = 5'd31.
  - Typedef `shadow_stage_t` {`valid`, `rd`, `reg_write`, `mem_read`}.
- Sub-module `forward_select`: combinational compare of one source register against two shadow stages, returning the 2-bit select. Instantiated twice, for A and B.

## Test plan
- ADD X1 at ID, then SUB X2,X1,X3 next cycle → `forwardA` = 10 in SUB's EX cycle. With one independent instruction between them → 01.
- LDUR X4 followed by ADD X5,X4,X6 → one cycle with `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1; ADD's EX then sees `forwardA` = 01.
- Writer to X31, then a reader of X31 → no forward (00), no stall.
- `branch_taken` pulse with `FLUSH_DEPTH` = 3 → all three flushes high for one cycle. The next two EX cycles show `forwardA` = `forwardB` = 00 despite matching registers from the squashed instructions.
- `dmem_wait` held 3 cycles during a load-use hazard → outputs frozen 3 cycles, then the single stall cycle. With `HAZARD_PERF_EN`, `stall_cycles` = 4.
- Reset asserted between clock edges mid-stall → `forwardA`/`forwardB` = 00 and `id_ex_bubble` = 0 immediately; counters = 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared forwarding encodings and pipeline shadow-stage type.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [4:0] XZR       = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } shadow_stage_t;

  localparam shadow_stage_t SHADOW_RESET = '{valid: 1'b0, rd: XZR, reg_write: 1'b0, mem_read: 1'b0};

  // XZR is never a hazard source.
  function automatic logic stage_writes(input shadow_stage_t s, input logic [4:0] src);
    return s.valid && s.reg_write && (s.rd != XZR) && (s.rd == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// ============================================================================
// Module      : forward_select
// Description : Compares one source register against the ID/EX and EX/MEM
//               shadow stages and returns the 2-bit operand select.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_select
  import pipeline_pkg::*;
(
  input  logic [4:0]    src_i,
  input  shadow_stage_t idex_i,
  input  shadow_stage_t exmem_i,
  output logic [1:0]    sel_o
);

  // The younger producer wins.
  always_comb begin
    sel_o = FWD_REG;
    if (stage_writes(idex_i, src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (stage_writes(exmem_i, src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_control.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control
// Description : Five-stage pipeline hazard controller: registered forwarding
//               selects, load-use stall, taken-branch flush, dmem freeze.
//               Optional performance counters under HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        branch_taken,
  input  logic        dmem_wait,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic FLUSH_ID_EX  = (FLUSH_DEPTH >= 2);
  localparam logic FLUSH_EX_MEM = (FLUSH_DEPTH >= 3);

  shadow_stage_t idex_q, idex_d;
  shadow_stage_t exmem_q, exmem_d;
  shadow_stage_t memwb_q, memwb_d;
  shadow_stage_t id_stage;
  logic [1:0]    fwd_a_q, fwd_a_d;
  logic [1:0]    fwd_b_q, fwd_b_d;
  logic [1:0]    sel_a, sel_b;
  logic          load_use;
  logic          do_flush;
  logic          do_stall;
  logic          unused_memwb;

  assign id_stage = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  forward_select u_fwd_a (
    .src_i   (id_rn),
    .idex_i  (idex_q),
    .exmem_i (exmem_q),
    .sel_o   (sel_a)
  );

  forward_select u_fwd_b (
    .src_i   (id_rm),
    .idex_i  (idex_q),
    .exmem_i (exmem_q),
    .sel_o   (sel_b)
  );

  always_comb begin
    load_use = idex_q.valid && idex_q.mem_read && (idex_q.rd != XZR) &&
               ((idex_q.rd == id_rn) || (id_uses_rm && (idex_q.rd == id_rm)));
    do_flush = !dmem_wait && branch_taken;
    do_stall = !dmem_wait && !branch_taken && load_use;
  end

  assign pc_write     = !dmem_wait && !do_stall;
  assign if_id_write  = !dmem_wait && !do_stall;
  assign id_ex_bubble = do_stall;
  assign flush_if_id  = do_flush;
  assign flush_id_ex  = do_flush && FLUSH_ID_EX;
  assign flush_ex_mem = do_flush && FLUSH_EX_MEM;
  assign forwardA     = fwd_a_q;
  assign forwardB     = fwd_b_q;

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!dmem_wait) begin
      memwb_d = exmem_q;
      exmem_d = idex_q;
      idex_d  = id_stage;
      fwd_a_d = sel_a;
      fwd_b_d = id_uses_rm ? sel_b : FWD_REG;
      if (do_flush) begin
        if (FLUSH_ID_EX) begin
          idex_d  = SHADOW_RESET;
          fwd_a_d = FWD_REG;
          fwd_b_d = FWD_REG;
        end
        if (FLUSH_EX_MEM) begin
          exmem_d = SHADOW_RESET;
        end
      end else if (do_stall) begin
        idex_d  = SHADOW_RESET;
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= SHADOW_RESET;
      exmem_q <= SHADOW_RESET;
      memwb_q <= SHADOW_RESET;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // MEM/WB is tracked for completeness; the WB value reaches EX via EX/MEM.
  assign unused_memwb = ^memwb_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((dmem_wait || do_stall) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (do_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire
